wb_host_arb: RTL

//  Round-robin Wishbone arbiter sharing the user-project WB slave port (behind
//  u_wb_host) between NUM_M masters, e.g. Caravel management WB and internal DMA/debug masters.

---
 rtl/wb_host_arb_pkg.sv | 13 +
 rtl/wb_rr_pick.sv | 34 +++
 rtl/wb_host_arb.sv | 126 ++++++++++++
 3 files changed

// File: rtl/wb_host_arb_pkg.sv
// Shared types and constants for the round-robin Wishbone host arbiter.
package wb_host_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_e;

    localparam int NUM_M_MAX   = 4;
    localparam int TMO_CYC_DEF = 200;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module wb_rr_pick
    import wb_host_arb_pkg::*;
#(
    parameter int NUM_M = 2,
    parameter int IW    = $clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] req_i,
    input  logic [IW-1:0]    last_i,
    output logic [NUM_M-1:0] pick_o,
    output logic [IW-1:0]    pick_idx_o
);

    logic [IW-1:0] cand;

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        pick_o     = '0;
        pick_idx_o = '0;
        cand       = '0;
        // Scan farthest-to-nearest so the nearest requester after 'last' overrides.
        for (int k = NUM_M_MAX; k >= 1; k--) begin
            if (k <= NUM_M) begin
                cand = IW'((int'(last_i) + k) % NUM_M);
                if (req_i[cand]) begin
                    pick_o       = '0;
                    pick_o[cand] = 1'b1;
                    pick_idx_o   = cand;
                end
            end
        end
    end

endmodule

// File: rtl/wb_host_arb.sv
// Round-robin Wishbone arbiter with per-CYC grant lock and a no-response watchdog.
module wb_host_arb
    import wb_host_arb_pkg::*;
#(
    parameter int NUM_M   = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TMO_W   = 8,
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [NUM_M-1:0]      m_cyc_i,
    input  logic [NUM_M-1:0]      m_stb_i,
    input  logic [NUM_M-1:0]      m_we_i,
    input  logic [NUM_M*AW-1:0]   m_adr_i,
    input  logic [NUM_M*DW-1:0]   m_dat_i,
    input  logic [NUM_M*DW/8-1:0] m_sel_i,
    output logic [DW-1:0]         m_dat_o,
    output logic [NUM_M-1:0]      m_ack_o,
    output logic [NUM_M-1:0]      m_err_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [AW-1:0]         s_adr_o,
    output logic [DW-1:0]         s_dat_o,
    output logic [DW/8-1:0]       s_sel_o,
    input  logic [DW-1:0]         s_dat_i,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    output logic [NUM_M-1:0]      gnt_o
);

    localparam int SW = DW / 8;
    localparam int IW = $clog2(NUM_M);

    arb_state_e       state_q, state_d;
    logic [NUM_M-1:0] gnt_q, gnt_d;
    logic [IW-1:0]    last_q, last_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [NUM_M-1:0] pick;
    logic [IW-1:0]    pick_idx;
    logic             wait_rsp;

    wb_rr_pick #(.NUM_M(NUM_M), .IW(IW)) u_pick (
        .req_i     (m_cyc_i),
        .last_i    (last_q),
        .pick_o    (pick),
        .pick_idx_o(pick_idx)
    );

    // last_q doubles as the granted master index while BUSY or ABORT.
    assign wait_rsp = m_stb_i[last_q] & ~s_ack_i & ~s_err_i;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            last_q  <= IW'(NUM_M - 1);
            tmo_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        tmo_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (|m_cyc_i) begin
                    state_d = ST_BUSY;
                    gnt_d   = pick;
                    last_d  = pick_idx;
                end
            end
            ST_BUSY: begin
                if (!m_cyc_i[last_q]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end else if (wait_rsp) begin
                    if (tmo_q == TMO_W'(TMO_CYC - 1)) state_d = ST_ABORT;
                    else                              tmo_d   = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_dat_o = s_dat_i;
        gnt_o   = gnt_q;
        case (state_q)
            ST_BUSY: begin
                s_cyc_o         = 1'b1;
                s_stb_o         = m_stb_i[last_q];
                s_we_o          = m_we_i[last_q];
                s_adr_o         = m_adr_i[int'(last_q)*AW +: AW];
                s_dat_o         = m_dat_i[int'(last_q)*DW +: DW];
                s_sel_o         = m_sel_i[int'(last_q)*SW +: SW];
                m_ack_o[last_q] = s_ack_i;
                m_err_o[last_q] = s_err_i;
            end
            ST_ABORT: m_err_o[last_q] = 1'b1;
            default: ;
        endcase
    end

endmodule
